// File: rtl/xsleena_video_timing_gen.sv
// Parametrised H/V raster timing generator: counters, flip-aware positions,
// delayed positions, blanking, syncs and line/frame/interrupt strobes.
module xsleena_video_timing_gen #(
  parameter int unsigned H_BITS     = 9,
  parameter int unsigned V_BITS     = 9,
  parameter int unsigned H_TOTAL    = 384,
  parameter int unsigned V_TOTAL    = 264,
  parameter int unsigned HBLK_START = 256,
  parameter int unsigned HBLK_END   = 0,
  parameter int unsigned HS_START   = 296,
  parameter int unsigned HS_END     = 328,
  parameter int unsigned VBLK_START = 240,
  parameter int unsigned VBLK_END   = 16,
  parameter int unsigned VS_START   = 248,
  parameter int unsigned VS_END     = 252,
  parameter int unsigned IRQ_STRIDE = 8,
  parameter int unsigned POS_DLY    = 1
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              cen,
  input  logic              flip,
  output logic [H_BITS-1:0] hcnt,
  output logic [V_BITS-1:0] vcnt,
  output logic [7:0]        hpos,
  output logic [7:0]        vpos,
  output logic [7:0]        dhpos,
  output logic [7:0]        dvpos,
  output logic              flip_l,
  output logic              hblk_n,
  output logic              vblk,
  output logic              vblk_n,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              csync_n,
  output logic              line_start,
  output logic              frame_start,
  output logic              vblk_irq,
  output logic              line_irq
);

  if (int'(H_BITS) < $clog2(H_TOTAL) || int'(V_BITS) < $clog2(V_TOTAL)) begin : g_bad_width
    $error("xsleena_video_timing_gen: counter width too small for H_TOTAL/V_TOTAL");
  end
  if (H_BITS < 8 || V_BITS < 8) begin : g_bad_pos_width
    $error("xsleena_video_timing_gen: H_BITS and V_BITS must be at least 8");
  end
  if (POS_DLY < 1) begin : g_bad_dly
    $error("xsleena_video_timing_gen: POS_DLY must be at least 1");
  end
  if (IRQ_STRIDE == 0 || (IRQ_STRIDE & (IRQ_STRIDE - 1)) != 0) begin : g_bad_stride
    $error("xsleena_video_timing_gen: IRQ_STRIDE must be a power of 2");
  end

  localparam logic [H_BITS-1:0] H_LAST     = H_BITS'(H_TOTAL - 1);
  localparam logic [V_BITS-1:0] V_LAST     = V_BITS'(V_TOTAL - 1);
  localparam logic [V_BITS-1:0] V_IRQ_MASK = V_BITS'(IRQ_STRIDE - 1);
  localparam logic [V_BITS-1:0] V_BLK_IRQ  = V_BITS'(VBLK_START);

  // S<E: plain interval; S>E: interval wraps through zero; S==E: never active.
  function automatic logic in_range(input logic [31:0] c, input logic [31:0] s,
                                    input logic [31:0] e);
    if (s < e)      return (c >= s) && (c < e);
    else if (s > e) return (c >= s) || (c < e);
    else            return 1'b0;
  endfunction

  logic              h_wrap, v_wrap;
  logic [H_BITS-1:0] hcnt_nx;
  logic [V_BITS-1:0] vcnt_nx;
  logic              line_nx, frame_nx, vblk_irq_nx, line_irq_nx, flip_nx;
  logic              hblk_nx, vblk_nx, hs_nx, vs_nx;
  logic [7:0]        hpipe [POS_DLY];
  logic [7:0]        vpipe [POS_DLY];

  always_comb begin
    h_wrap  = (hcnt == H_LAST);
    v_wrap  = (vcnt == V_LAST);
    hcnt_nx = h_wrap ? '0 : hcnt + H_BITS'(1);
    vcnt_nx = vcnt;
    if (h_wrap) vcnt_nx = v_wrap ? '0 : vcnt + V_BITS'(1);
    line_nx     = (hcnt_nx == '0);
    frame_nx    = line_nx && (vcnt_nx == '0);
    vblk_irq_nx = line_nx && (vcnt_nx == V_BLK_IRQ);
    line_irq_nx = line_nx && ((vcnt_nx & V_IRQ_MASK) == '0) && (vcnt_nx != '0);
    flip_nx     = frame_nx ? flip : flip_l;
    hblk_nx     = in_range(32'(hcnt_nx), HBLK_START, HBLK_END);
    vblk_nx     = in_range(32'(vcnt_nx), VBLK_START, VBLK_END);
    hs_nx       = in_range(32'(hcnt_nx), HS_START, HS_END);
    vs_nx       = in_range(32'(vcnt_nx), VS_START, VS_END);
  end

  // Decodes use the next-count values so every level lines up with hcnt/vcnt.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      hcnt        <= '0;
      vcnt        <= '0;
      hpos        <= '0;
      vpos        <= '0;
      flip_l      <= 1'b0;
      hblk_n      <= 1'b0;
      vblk        <= 1'b1;
      vblk_n      <= 1'b0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      csync_n     <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblk_irq    <= 1'b0;
      line_irq    <= 1'b0;
      for (int unsigned i = 0; i < POS_DLY; i++) begin
        hpipe[i] <= '0;
        vpipe[i] <= '0;
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblk_irq    <= 1'b0;
      line_irq    <= 1'b0;
      if (cen) begin
        hcnt        <= hcnt_nx;
        vcnt        <= vcnt_nx;
        flip_l      <= flip_nx;
        hpos        <= hcnt_nx[7:0] ^ {8{flip_nx}};
        vpos        <= vcnt_nx[7:0] ^ {8{flip_nx}};
        hblk_n      <= ~hblk_nx;
        vblk        <= vblk_nx;
        vblk_n      <= ~vblk_nx;
        hsync_n     <= ~hs_nx;
        vsync_n     <= ~vs_nx;
        csync_n     <= ~hs_nx ^ vs_nx;
        line_start  <= line_nx;
        frame_start <= frame_nx;
        vblk_irq    <= vblk_irq_nx;
        line_irq    <= line_irq_nx;
        hpipe[0]    <= hpos;
        vpipe[0]    <= vpos;
        for (int unsigned i = 1; i < POS_DLY; i++) begin
          hpipe[i] <= hpipe[i-1];
          vpipe[i] <= vpipe[i-1];
        end
      end
    end
  end

  assign dhpos = hpipe[POS_DLY-1];
  assign dvpos = vpipe[POS_DLY-1];

endmodule
